// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: bubble encoding, fault codes, IF/ID bundle.
package fetch_pkg;

   localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;

   localparam logic [1:0]  FAULT_NONE     = 2'b00;
   localparam logic [1:0]  FAULT_MISALIGN = 2'b01;
   localparam logic [1:0]  FAULT_RANGE    = 2'b10;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        valid;
   } ifid_t;

endpackage

// File: rtl/pc_gen.sv
// PC register with next-PC selection (reset / redirect / hold / +4) and ROM range compare.
module pc_gen
   import fetch_pkg::*;
#(
   parameter int          ROM_DEPTH = 1024,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        redirect_valid_i,
   input  logic [31:0] redirect_pc_i,
   input  logic        hold_i,
   output logic [31:0] pc_o,
   output logic        in_range_o
);

   localparam logic [29:0] DEPTH_W = 30'(ROM_DEPTH);

   logic [31:0] pc_q, pc_d;

   always_comb begin
      pc_d = pc_q + 32'd4;
      if (redirect_valid_i) pc_d = {redirect_pc_i[31:2], 2'b00};
      else if (hold_i)      pc_d = pc_q;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) pc_q <= RESET_PC;
      else         pc_q <= pc_d;
   end

   // Full word index is compared so a truncated ROM address can never alias into range.
   assign in_range_o = (pc_q[31:2] < DEPTH_W);
   assign pc_o       = pc_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: drives the ROM address from the PC and loads the IF/ID register, fault latch
// and fetch counter. RUN/PARKED is implied by the PC range check, not held as separate state.
module instr_fetch_stage #(
   parameter int          ADDR_W    = 10,
   parameter int          ROM_DEPTH = 1024,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic              CLK,
   input  logic              RESET_N,
   output logic [ADDR_W-1:0] ROM_ADDRESS,
   input  logic [31:0]       ROM_DATA,
   input  logic              STALL,
   input  logic              FLUSH,
   input  logic              REDIRECT_VALID,
   input  logic [31:0]       REDIRECT_PC,
   output logic [31:0]       IF_INSTR,
   output logic [31:0]       IF_PC,
   output logic              IF_VALID,
   output logic [1:0]        FAULT,
   output logic [31:0]       FETCH_COUNT
);

   import fetch_pkg::*;

   logic [31:0] pc;
   logic        in_range;
   logic        pc_hold;

   ifid_t       ifid_q, ifid_d;
   logic [1:0]  fault_q, fault_d;
   logic [31:0] cnt_q, cnt_d;

   // Flush refetches the same word, so every non-redirect, non-normal case holds the PC.
   assign pc_hold = FLUSH | STALL | ~in_range;

   pc_gen #(
      .ROM_DEPTH (ROM_DEPTH),
      .RESET_PC  (RESET_PC)
   ) u_pc_gen (
      .clk_i            (CLK),
      .rst_ni           (RESET_N),
      .redirect_valid_i (REDIRECT_VALID),
      .redirect_pc_i    (REDIRECT_PC),
      .hold_i           (pc_hold),
      .pc_o             (pc),
      .in_range_o       (in_range)
   );

   always_comb begin
      ifid_d  = ifid_q;
      fault_d = fault_q;
      cnt_d   = cnt_q;
      if (REDIRECT_VALID) begin
         ifid_d = '{instr: NOP_INSTR, pc: ifid_q.pc, valid: 1'b0};
         if (REDIRECT_PC[1:0] != 2'b00 && fault_q == FAULT_NONE) fault_d = FAULT_MISALIGN;
      end else if (FLUSH) begin
         ifid_d = '{instr: NOP_INSTR, pc: ifid_q.pc, valid: 1'b0};
      end else if (STALL) begin
         ifid_d = ifid_q;
      end else if (!in_range) begin
         ifid_d = '{instr: NOP_INSTR, pc: ifid_q.pc, valid: 1'b0};
         if (fault_q == FAULT_NONE) fault_d = FAULT_RANGE;
      end else begin
         ifid_d = '{instr: ROM_DATA, pc: pc, valid: 1'b1};
         cnt_d  = cnt_q + 32'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         ifid_q  <= '{instr: NOP_INSTR, pc: 32'h0, valid: 1'b0};
         fault_q <= FAULT_NONE;
         cnt_q   <= 32'h0;
      end else begin
         ifid_q  <= ifid_d;
         fault_q <= fault_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ROM_ADDRESS = pc[ADDR_W+1:2];
   assign IF_INSTR    = ifid_q.instr;
   assign IF_PC       = ifid_q.pc;
   assign IF_VALID    = ifid_q.valid;
   assign FAULT       = fault_q;
   assign FETCH_COUNT = cnt_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed-vector bench for instr_fetch_stage with an 8-word ROM so range parking is reachable.
module tb_instr_fetch_stage;

   localparam int ADDR_W = 10;

   logic              CLK = 1'b0;
   logic              RESET_N;
   logic [ADDR_W-1:0] ROM_ADDRESS;
   logic [31:0]       ROM_DATA;
   logic              STALL, FLUSH, REDIRECT_VALID;
   logic [31:0]       REDIRECT_PC;
   logic [31:0]       IF_INSTR, IF_PC, FETCH_COUNT;
   logic              IF_VALID;
   logic [1:0]        FAULT;

   logic [31:0] rom [0:15];
   int n_vec  = 0;
   int n_miss = 0;

   always #5 CLK = ~CLK;

   assign ROM_DATA = rom[ROM_ADDRESS[3:0]];

   instr_fetch_stage #(
      .ADDR_W    (ADDR_W),
      .ROM_DEPTH (8),
      .RESET_PC  (32'h0),
      .NOP_INSTR (32'h0000_0013)
   ) dut (
      .CLK            (CLK),
      .RESET_N        (RESET_N),
      .ROM_ADDRESS    (ROM_ADDRESS),
      .ROM_DATA       (ROM_DATA),
      .STALL          (STALL),
      .FLUSH          (FLUSH),
      .REDIRECT_VALID (REDIRECT_VALID),
      .REDIRECT_PC    (REDIRECT_PC),
      .IF_INSTR       (IF_INSTR),
      .IF_PC          (IF_PC),
      .IF_VALID       (IF_VALID),
      .FAULT          (FAULT),
      .FETCH_COUNT    (FETCH_COUNT)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_ifid(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                           input logic vld);
      chk({tag, ".instr"}, IF_INSTR, instr);
      chk({tag, ".pc"},    IF_PC,    pc);
      chk({tag, ".valid"}, 32'(IF_VALID), 32'(vld));
   endtask

   initial begin
      rom[0] = 32'h0000_0013; rom[1] = 32'h0010_0093;
      rom[2] = 32'h0010_0313; rom[3] = 32'h0040_0613;
      rom[4] = 32'h0060_2023; rom[5] = 32'h00a0_0513;
      rom[6] = 32'h00b0_0593; rom[7] = 32'h00c0_0613;
      for (int i = 8; i < 16; i++) rom[i] = 32'hdead_beef;

      RESET_N = 1'b0; STALL = 1'b0; FLUSH = 1'b0;
      REDIRECT_VALID = 1'b0; REDIRECT_PC = 32'h0;
      tick(); tick();
      chk_ifid("rst", 32'h13, 32'h0, 1'b0);
      chk("rst.fault", 32'(FAULT), 32'h0);
      chk("rst.cnt",   FETCH_COUNT, 32'h0);
      chk("rst.addr",  32'(ROM_ADDRESS), 32'h0);

      // Straight-line fetch of words 0..4
      RESET_N = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_ifid($sformatf("run%0d", i), rom[i], 32'(i * 4), 1'b1);
      end
      chk("run.cnt",  FETCH_COUNT, 32'd5);
      chk("run.addr", 32'(ROM_ADDRESS), 32'd5);

      STALL = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_ifid($sformatf("stall%0d", i), 32'h0060_2023, 32'h10, 1'b1);
         chk("stall.addr", 32'(ROM_ADDRESS), 32'd5);
         chk("stall.cnt",  FETCH_COUNT, 32'd5);
      end

      // Redirect beats a concurrent stall
      REDIRECT_VALID = 1'b1; REDIRECT_PC = 32'h14;
      tick();
      chk_ifid("redir", 32'h13, 32'h10, 1'b0);
      chk("redir.addr", 32'(ROM_ADDRESS), 32'd5);
      REDIRECT_VALID = 1'b0; STALL = 1'b0;
      tick();
      chk_ifid("redir.fetch", 32'h00a0_0513, 32'h14, 1'b1);
      chk("redir.cnt", FETCH_COUNT, 32'd6);

      REDIRECT_VALID = 1'b1; REDIRECT_PC = 32'h16;
      tick();
      chk("mis.addr",  32'(ROM_ADDRESS), 32'd5);
      chk("mis.fault", 32'(FAULT), 32'h1);
      REDIRECT_VALID = 1'b0;
      tick(); chk("mis.pc14", IF_PC, 32'h14);
      tick(); chk("mis.pc18", IF_PC, 32'h18);
      tick(); chk_ifid("mis.pc1c", 32'h00c0_0613, 32'h1c, 1'b1);
      chk("mis.cnt", FETCH_COUNT, 32'd9);

      // PC 0x20 is past the 8-word ROM: park, and the earlier fault code sticks
      tick();
      chk_ifid("park", 32'h13, 32'h1c, 1'b0);
      chk("park.addr",  32'(ROM_ADDRESS), 32'd8);
      chk("park.fault", 32'(FAULT), 32'h1);
      chk("park.cnt",   FETCH_COUNT, 32'd9);
      tick();
      chk("park2.addr",  32'(ROM_ADDRESS), 32'd8);
      chk("park2.valid", 32'(IF_VALID), 32'h0);

      REDIRECT_VALID = 1'b1; REDIRECT_PC = 32'h0;
      tick();
      chk("resume.addr", 32'(ROM_ADDRESS), 32'd0);
      REDIRECT_VALID = 1'b0;
      tick();
      chk_ifid("resume", 32'h13, 32'h0, 1'b1);
      chk("resume.cnt", FETCH_COUNT, 32'd10);
      tick();
      chk("resume.pc4", IF_PC, 32'h4);

      // Reset overrides flush/stall/redirect
      RESET_N = 1'b0; FLUSH = 1'b1; STALL = 1'b1;
      REDIRECT_VALID = 1'b1; REDIRECT_PC = 32'h40;
      tick();
      chk_ifid("mrst", 32'h13, 32'h0, 1'b0);
      chk("mrst.addr",  32'(ROM_ADDRESS), 32'd0);
      chk("mrst.fault", 32'(FAULT), 32'h0);
      chk("mrst.cnt",   FETCH_COUNT, 32'h0);

      RESET_N = 1'b1; STALL = 1'b0; REDIRECT_VALID = 1'b0;
      tick();
      chk("flush.valid", 32'(IF_VALID), 32'h0);
      chk("flush.addr",  32'(ROM_ADDRESS), 32'd0);
      chk("flush.cnt",   FETCH_COUNT, 32'h0);
      FLUSH = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk_ifid($sformatf("run2_%0d", i), rom[i], 32'(i * 4), 1'b1);
      end
      chk("run2.cnt", FETCH_COUNT, 32'd8);
      tick();
      chk("oor.fault", 32'(FAULT), 32'h2);
      chk("oor.valid", 32'(IF_VALID), 32'h0);
      chk("oor.addr",  32'(ROM_ADDRESS), 32'd8);
      chk("oor.cnt",   FETCH_COUNT, 32'd8);

      REDIRECT_VALID = 1'b1; REDIRECT_PC = 32'h2;
      tick();
      chk("oor.mis.fault", 32'(FAULT), 32'h2);
      chk("oor.mis.addr",  32'(ROM_ADDRESS), 32'd0);
      REDIRECT_VALID = 1'b0;
      tick();
      chk_ifid("oor.resume", 32'h13, 32'h0, 1'b1);

      // Word 1025 truncates onto ROM word 1 but must not be fetched
      REDIRECT_VALID = 1'b1; REDIRECT_PC = 32'h1004;
      tick();
      chk("alias.addr", 32'(ROM_ADDRESS), 32'd1);
      REDIRECT_VALID = 1'b0;
      tick();
      chk_ifid("alias", 32'h13, 32'h0, 1'b0);
      chk("alias.cnt", FETCH_COUNT, 32'd9);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
